// File: rtl/sram_responder.sv
// Responder-side SRAM model: any input change opens an access window, and the
// access commits only after ACCESS_CYCLES stable cycles (emulates async SRAM timing).
module sram_responder #(
  parameter int ADDR_BITS     = 16,
  parameter int DEPTH_BITS    = 8,
  parameter int DATA_BITS     = 32,
  parameter int ACCESS_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_enable,
  input  logic                 write_enable,
  input  logic [0:ADDR_BITS-1] address,
  input  logic [DATA_BITS-1:0] w_data,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 busy,
  output logic                 access_done,
  output logic                 conflict_err,
  output logic                 range_err
);

  localparam int CNT_BITS = $clog2(ACCESS_CYCLES + 1);
  localparam int WORDS    = 1 << DEPTH_BITS;

  typedef enum logic {IDLE, PEND} state_t;

  state_t                state_reg, state_next;
  logic [CNT_BITS-1:0]   count_reg, count_next;
  logic                  snap_re_reg, snap_we_reg;
  logic [0:ADDR_BITS-1]  snap_addr_reg;
  logic [DATA_BITS-1:0]  snap_wdata_reg;
  logic                  changed, complete;
  logic [ADDR_BITS-1:0]  snap_addr_num;
  logic [DEPTH_BITS-1:0] index;
  logic                  out_of_range;

  logic [DATA_BITS-1:0]  mem [WORDS];

  assign changed = {read_enable, write_enable, address, w_data} !=
                   {snap_re_reg, snap_we_reg, snap_addr_reg, snap_wdata_reg};

  // Bit 0 of the address is the MSB, so a plain copy yields the numeric value.
  assign snap_addr_num = snap_addr_reg;
  assign index         = snap_addr_num[DEPTH_BITS-1:0];
  assign out_of_range  = (snap_addr_num >> DEPTH_BITS) != '0;

  assign busy = (state_reg == PEND);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    complete   = 1'b0;
    if (changed) begin
      count_next = '0;
      state_next = (read_enable || write_enable) ? PEND : IDLE;
    end else if (state_reg == PEND) begin
      if (count_reg == CNT_BITS'(ACCESS_CYCLES - 1)) begin
        complete   = 1'b1;
        state_next = IDLE;
        count_next = '0;
      end else begin
        count_next = count_reg + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      snap_re_reg    <= 1'b0;
      snap_we_reg    <= 1'b0;
      snap_addr_reg  <= '0;
      snap_wdata_reg <= '0;
      r_data         <= '0;
      access_done    <= 1'b0;
      conflict_err   <= 1'b0;
      range_err      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      access_done  <= complete;
      conflict_err <= complete && snap_re_reg && snap_we_reg;
      range_err    <= complete && out_of_range;
      if (changed) begin
        snap_re_reg    <= read_enable;
        snap_we_reg    <= write_enable;
        snap_addr_reg  <= address;
        snap_wdata_reg <= w_data;
      end
      if (complete && snap_re_reg && !snap_we_reg)
        r_data <= out_of_range ? '0 : mem[index];
    end
  end

  // Array is never reset; complete is low while reset holds state in IDLE.
  always_ff @(posedge clk) begin
    if (complete && snap_we_reg && !snap_re_reg && !out_of_range)
      mem[index] <= snap_wdata_reg;
  end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios plus random traffic,
// checked every cycle against a window/age reference model.
module tb_sram_responder;
  localparam int AB = 16;
  localparam int DB = 8;
  localparam int DW = 32;
  localparam int AC = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          read_enable = 1'b0;
  logic          write_enable = 1'b0;
  logic [0:AB-1] address = '0;
  logic [DW-1:0] w_data = '0;
  logic [DW-1:0] r_data;
  logic          busy, access_done, conflict_err, range_err;

  sram_responder #(.ADDR_BITS(AB), .DEPTH_BITS(DB), .DATA_BITS(DW), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .w_data(w_data), .r_data(r_data), .busy(busy),
    .access_done(access_done), .conflict_err(conflict_err), .range_err(range_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic          s_re, s_we;
  logic [AB-1:0] s_addr;
  logic [DW-1:0] s_wd;
  bit            win_open;
  int            age;
  logic [DW-1:0] m_data [1 << DB];
  bit            m_known [1 << DB];
  logic [DW-1:0] e_rd;
  bit            e_rd_known;
  bit            e_done, e_conf, e_range;
  int            cnt_done, cnt_conf, cnt_range;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    s_re = 0; s_we = 0; s_addr = '0; s_wd = '0;
    win_open = 0; age = 0;
    e_rd = '0; e_rd_known = 1;
    e_done = 0; e_conf = 0; e_range = 0;
  endtask

  // One rising edge seen from the outside: a change restarts the window,
  // otherwise the window ages and the access happens when age reaches AC.
  task automatic model_edge();
    logic [AB-1:0] an;
    int idx;
    bit oor;
    e_done = 0; e_conf = 0; e_range = 0;
    an = address;
    if (read_enable != s_re || write_enable != s_we || an != s_addr || w_data != s_wd) begin
      s_re = read_enable; s_we = write_enable; s_addr = an; s_wd = w_data;
      win_open = read_enable || write_enable;
      age = 0;
    end else if (win_open) begin
      age++;
      if (age == AC) begin
        win_open = 0;
        idx = int'(s_addr % (1 << DB));
        oor = (s_addr >= (1 << DB));
        e_done = 1;
        e_range = oor;
        if (s_re && s_we) e_conf = 1;
        else if (s_re) begin
          if (oor) begin e_rd = '0; e_rd_known = 1; end
          else begin e_rd = m_data[idx]; e_rd_known = m_known[idx]; end
        end else if (!oor) begin
          m_data[idx] = s_wd; m_known[idx] = 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_busy"}, DW'(busy), DW'(win_open));
    check({tag, "_done"}, DW'(access_done), DW'(e_done));
    check({tag, "_conf"}, DW'(conflict_err), DW'(e_conf));
    check({tag, "_range"}, DW'(range_err), DW'(e_range));
    if (e_rd_known) check({tag, "_rdata"}, r_data, e_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("cyc");
    if (access_done) cnt_done++;
    if (conflict_err) cnt_conf++;
    if (range_err) cnt_range++;
  endtask

  task automatic hold(input bit re, input bit we, input logic [AB-1:0] a,
                      input logic [DW-1:0] d, input int n);
    read_enable = re; write_enable = we; address = a; w_data = d;
    repeat (n) tick();
  endtask

  // Asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    read_enable = 0; write_enable = 0; address = '0; w_data = '0;
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    rst = 1'b1;
  endtask

  task automatic clear_counts();
    cnt_done = 0; cnt_conf = 0; cnt_range = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << DB); i++) begin m_known[i] = 0; m_data[i] = '0; end
    model_reset();
    #2;
    do_reset();

    // Preload a few known locations
    hold(0, 1, 16'h0000, 32'h11110000, 12);
    hold(0, 1, 16'h0003, 32'h33333333, 12);
    hold(0, 1, 16'h0005, 32'h55555555, 12);
    hold(0, 1, 16'h0030, 32'h30303030, 12);
    hold(0, 0, 16'h0000, 32'h0, 2);
    do_reset();

    // Read held stable: one access only
    clear_counts();
    hold(1, 0, 16'h0005, 32'h0, 25);
    check("s1_done_cnt", cnt_done, 1);
    check("s1_rdata", r_data, 32'h55555555);

    // Write then read back
    clear_counts();
    hold(0, 1, 16'h0010, 32'hDEADBEEF, 12);
    hold(1, 0, 16'h0010, 32'h0, 12);
    check("s2_rdata", r_data, 32'hDEADBEEF);
    check("s2_done_cnt", cnt_done, 2);

    // Data change mid-window restarts it; second data lands
    clear_counts();
    hold(0, 1, 16'h0020, 32'hAAAA0001, 5);
    hold(0, 1, 16'h0020, 32'hBBBB0002, 12);
    check("s3_write_done_cnt", cnt_done, 1);
    hold(1, 0, 16'h0020, 32'h0, 12);
    check("s3_rdata", r_data, 32'hBBBB0002);

    // Both enables: conflict, no access
    clear_counts();
    hold(1, 1, 16'h0003, 32'hFFFFFFFF, 12);
    check("s4_conf_cnt", cnt_conf, 1);
    check("s4_done_cnt", cnt_done, 1);
    check("s4_rdata_kept", r_data, 32'hBBBB0002);
    hold(1, 0, 16'h0003, 32'h0, 12);
    check("s4_mem3", r_data, 32'h33333333);

    // Out-of-range read and write, no aliasing
    clear_counts();
    hold(1, 0, 16'h0100, 32'h0, 12);
    check("s5_range_cnt", cnt_range, 1);
    check("s5_rdata", r_data, 32'h0);
    hold(0, 1, 16'h0100, 32'h0BADF00D, 12);
    hold(1, 0, 16'h0000, 32'h0, 12);
    check("s5_no_alias", r_data, 32'h11110000);
    check("s5_range_cnt2", cnt_range, 2);

    // Reset mid-window aborts the write
    hold(0, 1, 16'h0030, 32'hCAFEF00D, 4);
    do_reset();
    clear_counts();
    hold(1, 0, 16'h0030, 32'h0, 12);
    check("s6_rdata", r_data, 32'h30303030);
    check("s6_done_cnt", cnt_done, 1);

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      logic [AB-1:0] a;
      logic [DW-1:0] d;
      int en;
      a = ($urandom_range(0, 9) == 0) ? (16'h0100 | AB'($urandom_range(0, 7)))
                                      : AB'($urandom_range(0, 7));
      d = ($urandom_range(0, 3) == 0) ? w_data ^ 32'h1 : $urandom;
      en = $urandom_range(0, 9);
      if ($urandom_range(0, 39) == 0) do_reset();
      hold(en < 4, (en >= 4 && en < 8) || en == 8, a, d, $urandom_range(1, 14));
    end
    hold(0, 0, 16'h0000, 32'h0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
